reg_scoreboard: RTL

- Parametrised register scoreboard for the in-order issue stage.
- Tracks outstanding writes per architectural register with a small counter, so several writes to one register can be in flight at once.
- Accepts NWB writeback ports per cycle and produces the issue stall/hazard decision itself.
- Sits between decode (issue request) and the writeback stages; replaces the single-bit invalid-register tracker.

---
 rtl/sb_pkg.sv | 28 ++
 rtl/sb_counter.sv | 28 ++
 rtl/reg_scoreboard.sv | 65 ++++++
 3 files changed

// File: rtl/sb_pkg.sv
// sb_pkg: shared defaults, counter type and writeback-match helper for the register scoreboard
package sb_pkg;
    localparam int DEF_NREG = 8;
    localparam int DEF_NWB  = 2;
    localparam int DEF_CNTW = 2;
    localparam int MAX_NWB  = 8;
    localparam int MAX_ADRW = 8;

    typedef logic [DEF_CNTW-1:0] cnt_t;

    // Ports are packed at a runtime stride of adrw bits inside a max-sized vector.
    function automatic logic [3:0] popcount_match(
        input logic [MAX_NWB-1:0]          valid,
        input logic [MAX_NWB*MAX_ADRW-1:0] adr_vec,
        input int                          adrw,
        input logic [MAX_ADRW-1:0]         r
    );
        logic [MAX_NWB*MAX_ADRW-1:0] sh;
        logic [MAX_ADRW-1:0]         mask;
        popcount_match = '0;
        mask = MAX_ADRW'((32'd1 << adrw) - 32'd1);
        for (int k = 0; k < MAX_NWB; k++) begin
            sh = adr_vec >> (k * adrw);
            if (valid[k] && ((sh[MAX_ADRW-1:0] & mask) == r))
                popcount_match = popcount_match + 4'd1;
        end
    endfunction
endpackage

// File: rtl/sb_counter.sv
// sb_counter: outstanding-write counter for one architectural register
module sb_counter #(
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            inc,
    input  logic [CNTW+1:0] dec,
    input  logic            flush,
    output logic [CNTW-1:0] count,
    output logic            busy,
    output logic            underflow
);
    logic [CNTW+1:0] sum;
    logic [CNTW+1:0] diff;

    assign sum       = {2'b00, count} + {{(CNTW+1){1'b0}}, inc};
    assign diff      = sum - dec;
    assign underflow = ~flush & (sum < dec);
    assign busy      = count != '0;

    always_ff @(posedge clk) begin
        if (!reset_n)
            count <= '0;
        else
            count <= (flush || sum < dec) ? '0 : diff[CNTW-1:0];
    end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register outstanding-write tracking with issue hazard/ack decision
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int ADRW   = $clog2(NREG),
    parameter int NWB    = DEF_NWB,
    parameter int CNTW   = DEF_CNTW,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_req,
    input  logic              issue_wr,
    input  logic [ADRW-1:0]   issue_dst,
    input  logic [1:0]        issue_rs_en,
    input  logic [ADRW-1:0]   issue_rs,
    input  logic [ADRW-1:0]   issue_rt,
    output logic              issue_ack,
    output logic              stall,
    input  logic [NWB-1:0]    wb_valid,
    input  logic [NWB*ADRW-1:0] wb_adr,
    input  logic              flush,
    output logic [NREG-1:0]   register_invalid,
    output logic              err_underflow
);
    logic [CNTW-1:0] cnt [NREG];
    logic [CNTW+1:0] dec [NREG];
    logic [NREG-1:0] inc;
    logic [NREG-1:0] uf;
    logic            rs_busy;
    logic            rt_busy;
    logic            hazard;

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        assign dec[r] = (CNTW+2)'(popcount_match(MAX_NWB'(wb_valid),
                                                  (MAX_NWB*MAX_ADRW)'(wb_adr),
                                                  ADRW, MAX_ADRW'(r)));
        assign inc[r] = issue_ack & issue_wr & (issue_dst == ADRW'(r));
        sb_counter #(.CNTW(CNTW)) u_cnt (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .flush     (flush),
            .count     (cnt[r]),
            .busy      (register_invalid[r]),
            .underflow (uf[r])
        );
    end

    // With bypass, a source whose outstanding writes all retire this cycle is free.
    assign rs_busy   = (BYPASS != 0) ? ({2'b00, cnt[issue_rs]} != dec[issue_rs]) : (cnt[issue_rs] != '0);
    assign rt_busy   = (BYPASS != 0) ? ({2'b00, cnt[issue_rt]} != dec[issue_rt]) : (cnt[issue_rt] != '0);
    assign hazard    = (issue_rs_en[0] & rs_busy) | (issue_rs_en[1] & rt_busy) | (issue_wr & (cnt[issue_dst] == '1));
    assign issue_ack = issue_req & ~hazard & ~flush;
    assign stall     = issue_req & ~issue_ack;

    always_ff @(posedge clk) begin
        if (!reset_n)
            err_underflow <= 1'b0;
        else if (|uf)
            err_underflow <= 1'b1;
    end
endmodule
